rf_wb_arbiter: RTL and testbench

Arbitrates the single register-file write port (WR / addr_WR / Din) between two writeback sources.
- Primary: the main pipeline WB stage.
- Secondary: the multi-cycle MUL/DIV unit.
Fixed priority goes to the primary, with a starvation counter that forces a secondary grant. A registered write stage drives the RF, and the block forwards the in-flight write to the RF read ports.

---
 rtl/rf_wb_arbiter_if.sv | 51 +++++
 rtl/rf_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter_if : writeback request / RF write / forwarding bundle
// Rev 1.0
// ============================================================================
interface rf_wb_arbiter_if #(
  parameter int AWL = 5,
  parameter int DWL = 32
);
  logic           p_valid;
  logic [AWL-1:0] p_addr;
  logic [DWL-1:0] p_data;
  logic           p_ready;
  logic           s_valid;
  logic [AWL-1:0] s_addr;
  logic [DWL-1:0] s_data;
  logic           s_ready;
  logic           WR;
  logic [AWL-1:0] addr_WR;
  logic [DWL-1:0] Din;
  logic [AWL-1:0] addr1;
  logic [AWL-1:0] addr2;
  logic [DWL-1:0] rf_dout1;
  logic [DWL-1:0] rf_dout2;
  logic [DWL-1:0] rdata1;
  logic [DWL-1:0] rdata2;
`ifdef RF_WB_STATS_EN
  logic [15:0]    p_cnt;
  logic [15:0]    s_cnt;
  logic [15:0]    force_cnt;
`endif

  modport master (
    output p_valid, p_addr, p_data, s_valid, s_addr, s_data,
    output addr1, addr2, rf_dout1, rf_dout2,
    input  p_ready, s_ready, WR, addr_WR, Din, rdata1, rdata2
`ifdef RF_WB_STATS_EN
    , input p_cnt, s_cnt, force_cnt
`endif
  );

  modport slave (
    input  p_valid, p_addr, p_data, s_valid, s_addr, s_data,
    input  addr1, addr2, rf_dout1, rf_dout2,
    output p_ready, s_ready, WR, addr_WR, Din, rdata1, rdata2
`ifdef RF_WB_STATS_EN
    , output p_cnt, s_cnt, force_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter : primary/secondary RF writeback arbiter with starvation
// guard, registered write stage and read forwarding. Optional transfer
// statistics when RF_WB_STATS_EN is defined.
// Rev 1.0
// ============================================================================
module rf_wb_arbiter #(
  parameter int AWL        = 5,
  parameter int DWL        = 32,
  parameter int STARVE_MAX = 3
) (
  input  wire logic       CLK,
  input  wire logic       RST,
  rf_wb_arbiter_if.slave  bus
);

  localparam logic [0:0] S_NORM  = 1'b0;
  localparam logic [0:0] S_FORCE = 1'b1;
  localparam logic [3:0] C_STARVE_LAST = 4'(STARVE_MAX - 1);

  logic [0:0]     r_state;
  logic [0:0]     w_state_nxt;
  logic [3:0]     r_starve;
  logic           w_p_ready;
  logic           w_s_ready;
  logic           w_p_xfer;
  logic           w_s_xfer;
  logic           w_s_denied;
  logic [AWL-1:0] w_g_addr;
  logic [DWL-1:0] w_g_data;
  logic           r_wr;
  logic [AWL-1:0] r_addr;
  logic [DWL-1:0] r_din;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_NORM;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NORM:  if (w_s_denied && (r_starve == C_STARVE_LAST)) w_state_nxt = S_FORCE;
      S_FORCE: if (w_s_xfer || !bus.s_valid)                  w_state_nxt = S_NORM;
      default: w_state_nxt = S_NORM;
    endcase
  end

  always_comb begin
    w_p_ready = 1'b1;
    w_s_ready = !bus.p_valid;
    case (r_state)
      S_FORCE: begin
        w_p_ready = 1'b0;
        w_s_ready = 1'b1;
      end
      default: begin
        w_p_ready = 1'b1;
        w_s_ready = !bus.p_valid;
      end
    endcase
  end

  assign bus.p_ready = w_p_ready;
  assign bus.s_ready = w_s_ready;
  assign w_p_xfer    = bus.p_valid && w_p_ready;
  assign w_s_xfer    = bus.s_valid && w_s_ready;
  assign w_s_denied  = bus.s_valid && !w_s_ready;

  // Count saturates at 15 so a large STARVE_MAX can never wrap past its trigger.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                             r_starve <= 4'd0;
    else if (!bus.s_valid || w_s_xfer)    r_starve <= 4'd0;
    else if (w_s_denied && r_starve != 4'hF) r_starve <= r_starve + 4'd1;
  end

  assign w_g_addr = w_s_xfer ? bus.s_addr : bus.p_addr;
  assign w_g_data = w_s_xfer ? bus.s_data : bus.p_data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_wr <= (w_p_xfer || w_s_xfer) && (w_g_addr != '0);
      if (w_p_xfer || w_s_xfer) begin
        r_addr <= w_g_addr;
        r_din  <= w_g_data;
      end
    end
  end

  assign bus.WR      = r_wr;
  assign bus.addr_WR = r_addr;
  assign bus.Din     = r_din;

  // r_wr is never set for register 0, so x0 reads always come from the RF.
  assign bus.rdata1 = (r_wr && (bus.addr1 == r_addr)) ? r_din : bus.rf_dout1;
  assign bus.rdata2 = (r_wr && (bus.addr2 == r_addr)) ? r_din : bus.rf_dout2;

`ifdef RF_WB_STATS_EN
  logic [15:0] r_p_cnt;
  logic [15:0] r_s_cnt;
  logic [15:0] r_force_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_p_cnt     <= 16'd0;
      r_s_cnt     <= 16'd0;
      r_force_cnt <= 16'd0;
    end else begin
      if (w_p_xfer && r_p_cnt != 16'hFFFF) r_p_cnt <= r_p_cnt + 16'd1;
      if (w_s_xfer && r_s_cnt != 16'hFFFF) r_s_cnt <= r_s_cnt + 16'd1;
      if (r_state == S_NORM && w_state_nxt == S_FORCE) r_force_cnt <= r_force_cnt + 16'd1;
    end
  end

  assign bus.p_cnt     = r_p_cnt;
  assign bus.s_cnt     = r_s_cnt;
  assign bus.force_cnt = r_force_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_wb_arbiter : scoreboard bench for rf_wb_arbiter (reference model of
// grant/starvation rules, expected writes queued at acceptance).
// Rev 1.0
// ============================================================================
module tb_rf_wb_arbiter;
  localparam int AWL = 5;
  localparam int DWL = 32;
  localparam int STARVE_MAX = 3;

  typedef struct {
    logic           wr;
    logic [AWL-1:0] a;
    logic [DWL-1:0] d;
  } exp_t;

  logic CLK;
  logic RST;
  rf_wb_arbiter_if #(.AWL(AWL), .DWL(DWL)) bus ();

  rf_wb_arbiter #(.AWL(AWL), .DWL(DWL), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t sb[$];

  bit             m_force;
  int             m_cnt;
  logic [AWL-1:0] m_addr;
  logic [DWL-1:0] m_din;
  int             m_pc, m_sc, m_fc;
  bit             last_p_acc, last_s_acc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_force = 1'b0; m_cnt = 0; m_addr = '0; m_din = '0;
    m_pc = 0; m_sc = 0; m_fc = 0;
    sb.delete();
  endtask

  // One clock cycle: drive at negedge, check readys, queue the expected write,
  // then check the write stage and forwarding after the edge.
  task automatic cycle(input bit pv, input logic [AWL-1:0] pa, input logic [DWL-1:0] pd,
                       input bit sv, input logic [AWL-1:0] sa, input logic [DWL-1:0] sd);
    exp_t e;
    bit epr, esr, px, sx, den, nf;
    logic [DWL-1:0] r1, r2;
    bus.p_valid = pv; bus.p_addr = pa; bus.p_data = pd;
    bus.s_valid = sv; bus.s_addr = sa; bus.s_data = sd;
    #1;
    epr = !m_force;
    esr = m_force ? 1'b1 : !pv;
    chk("p_ready", 64'(bus.p_ready), 64'(epr));
    chk("s_ready", 64'(bus.s_ready), 64'(esr));
    px  = pv && epr;
    sx  = sv && esr;
    den = sv && !esr;
    e.wr = 1'b0; e.a = m_addr; e.d = m_din;
    if (px) begin
      e.wr = (pa != 0); e.a = pa; e.d = pd; m_pc++;
    end else if (sx) begin
      e.wr = (sa != 0); e.a = sa; e.d = sd; m_sc++;
    end
    m_addr = e.a; m_din = e.d;
    sb.push_back(e);
    last_p_acc = px; last_s_acc = sx;
    nf = m_force;
    if (!m_force && den && m_cnt == STARVE_MAX - 1) begin nf = 1'b1; m_fc++; end
    else if (m_force && (sx || !sv)) nf = 1'b0;
    m_force = nf;
    if (!sv || sx) m_cnt = 0;
    else if (den && m_cnt < 15) m_cnt++;
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("WR", 64'(bus.WR), 64'(e.wr));
    chk("addr_WR", 64'(bus.addr_WR), 64'(e.a));
    chk("Din", 64'(bus.Din), 64'(e.d));
    r1 = $urandom; r2 = $urandom;
    bus.rf_dout1 = r1; bus.rf_dout2 = r2;
    bus.addr1 = e.a; bus.addr2 = e.a + 5'd1;
    #1;
    chk("rdata1", 64'(bus.rdata1), 64'(e.wr ? e.d : r1));
    chk("rdata2", 64'(bus.rdata2), 64'(r2));
    @(negedge CLK);
  endtask

  bit             rp_v, rs_v;
  logic [AWL-1:0] rp_a, rs_a;
  logic [DWL-1:0] rp_d, rs_d;

  initial begin
    RST = 1'b0;
    bus.p_valid = 0; bus.p_addr = '0; bus.p_data = '0;
    bus.s_valid = 0; bus.s_addr = '0; bus.s_data = '0;
    bus.addr1 = '0; bus.addr2 = '0; bus.rf_dout1 = '0; bus.rf_dout2 = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Reset then idle
    chk("rst_WR", 64'(bus.WR), 64'd0);
    chk("rst_addr_WR", 64'(bus.addr_WR), 64'd0);
    chk("rst_Din", 64'(bus.Din), 64'd0);
    chk("rst_p_ready", 64'(bus.p_ready), 64'd1);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
    cycle(0, 0, 0, 0, 0, 0);

    // Primary only
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Starvation: three denials, forced grant on the fourth, then back to NORM
    repeat (4) cycle(1, 3, 32'h0000_1111, 1, 9, 32'h12);
    cycle(1, 4, 32'h0000_2222, 1, 10, 32'h13);
    cycle(0, 0, 0, 0, 0, 0);

    // Zero register is accepted but dropped
    cycle(1, 0, 32'hFFFFFFFF, 0, 0, 0);

    // Secondary only
    cycle(0, 0, 0, 1, 31, 32'hA5A5A5A5);
    cycle(0, 0, 0, 0, 0, 0);

    // Reset mid-FORCE
    repeat (3) cycle(1, 6, 32'h0000_6666, 1, 12, 32'h34);
    #1;
    chk("force_p_ready", 64'(bus.p_ready), 64'd0);
    chk("force_s_ready", 64'(bus.s_ready), 64'd1);
    RST = 1'b0;
    #1;
    chk("arst_WR", 64'(bus.WR), 64'd0);
    chk("arst_addr_WR", 64'(bus.addr_WR), 64'd0);
    chk("arst_p_ready", 64'(bus.p_ready), 64'd1);
    chk("arst_s_ready", 64'(bus.s_ready), 64'd0);
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    cycle(1, 7, 32'h0000_7777, 1, 12, 32'h34);
    cycle(0, 0, 0, 1, 12, 32'h34);

    // Random traffic; requesters hold a request until it is accepted
    rp_v = 0; rs_v = 0; rp_a = '0; rs_a = '0; rp_d = '0; rs_d = '0;
    last_p_acc = 1; last_s_acc = 1;
    for (int i = 0; i < 300; i++) begin
      if (!rp_v || last_p_acc) begin
        rp_v = ($urandom_range(0, 3) != 0);
        rp_a = AWL'($urandom); rp_d = $urandom;
      end
      if (!rs_v || last_s_acc) begin
        rs_v = ($urandom_range(0, 2) != 0);
        rs_a = AWL'($urandom); rs_d = $urandom;
      end
      cycle(rp_v, rp_a, rp_d, rs_v, rs_a, rs_d);
    end
    cycle(0, 0, 0, 0, 0, 0);

`ifdef RF_WB_STATS_EN
    chk("p_cnt", 64'(bus.p_cnt), 64'(m_pc));
    chk("s_cnt", 64'(bus.s_cnt), 64'(m_sc));
    chk("force_cnt", 64'(bus.force_cnt), 64'(m_fc));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
